// File: rtl/reset_req_sequencer.sv
// Multi-channel reset-request sequencer: synchronises and edge-detects each request line,
// queues one request per channel and issues fixed-length pulses in priority order.
module reset_req_sequencer #(
  parameter int unsigned                 NUM_CH      = 3,
  parameter int unsigned                 CNT_W       = 8,
  parameter logic [NUM_CH*CNT_W-1:0]     PULSE_LEN   = {8'd31, 8'd2, 8'd6},
  parameter int unsigned                 GAP         = 4,
  parameter int unsigned                 SYNC_STAGES = 2,
  parameter bit                          PREEMPT     = 1'b0,
  localparam int unsigned                CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NUM_CH-1:0] req_in,
  output logic [NUM_CH-1:0] pulse_out,
  output logic              busy,
  output logic [CH_W-1:0]   active_ch,
  output logic [NUM_CH-1:0] pending,
  output logic              dropped
);

  localparam logic [CNT_W-1:0] GAP_M1 = CNT_W'((GAP > 0) ? GAP - 1 : 0);

  typedef enum logic [1:0] {StIdle, StPulse, StGuard} state_e;

  state_e                              state_q, state_d;
  logic [SYNC_STAGES-1:0][NUM_CH-1:0]  sync_q;
  logic [NUM_CH-1:0]                   hist_q;
  logic [NUM_CH-1:0]                   pending_q, pending_d;
  logic [NUM_CH-1:0]                   pulse_q, pulse_d;
  logic [CNT_W-1:0]                    cnt_q, cnt_d;
  logic [CH_W-1:0]                     active_q, active_d;
  logic                                dropped_q, dropped_d;

  logic [NUM_CH-1:0] req_edge, consume, sel_oh;
  logic [CH_W-1:0]   sel;
  logic [CNT_W-1:0]  sel_len_m1;
  logic              higher_pend, abort;

  assign req_edge = sync_q[SYNC_STAGES-1] & ~hist_q;

  // Lowest pending index wins; the loop runs high-to-low so the last match sticks.
  always_comb begin
    sel = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (pending_q[i]) sel = CH_W'(i);
    end
  end

  always_comb begin
    sel_oh      = '0;
    sel_len_m1  = '0;
    higher_pend = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      sel_oh[i] = (CH_W'(i) == sel);
      if (CH_W'(i) == sel) begin
        sel_len_m1 = (PULSE_LEN[i*CNT_W +: CNT_W] == '0) ? '0
                                                         : PULSE_LEN[i*CNT_W +: CNT_W] - 1'b1;
      end
      if (pending_q[i] && (CH_W'(i) < active_q)) higher_pend = 1'b1;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    active_d = active_q;
    pulse_d  = pulse_q;
    consume  = '0;
    abort    = 1'b0;
    case (state_q)
      StIdle: begin
        if (|pending_q) begin
          consume  = sel_oh;
          pulse_d  = sel_oh;
          active_d = sel;
          cnt_d    = sel_len_m1;
          state_d  = StPulse;
        end
      end
      StPulse: begin
        if ((PREEMPT && higher_pend) || (cnt_q == '0)) begin
          abort   = PREEMPT && higher_pend;
          pulse_d = '0;
          if (GAP == 0) begin
            state_d  = StIdle;
            active_d = '0;
            cnt_d    = '0;
          end else begin
            state_d = StGuard;
            cnt_d   = GAP_M1;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StGuard: begin
        if (cnt_q == '0) begin
          state_d  = StIdle;
          active_d = '0;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: begin
        state_d  = StIdle;
        active_d = '0;
        pulse_d  = '0;
      end
    endcase
  end

  // A fresh edge beats a same-cycle consume; it only counts as lost if the slot stays full.
  assign pending_d = (pending_q & ~consume) | req_edge;
  assign dropped_d = abort | (|(req_edge & pending_q & ~consume));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q    <= '1;
      hist_q    <= '1;
      pending_q <= '0;
      pulse_q   <= '0;
      cnt_q     <= '0;
      active_q  <= '0;
      dropped_q <= 1'b0;
      state_q   <= StIdle;
    end else begin
      sync_q    <= {sync_q[SYNC_STAGES-2:0], req_in};
      hist_q    <= sync_q[SYNC_STAGES-1];
      pending_q <= pending_d;
      pulse_q   <= pulse_d;
      cnt_q     <= cnt_d;
      active_q  <= active_d;
      dropped_q <= dropped_d;
      state_q   <= state_d;
    end
  end

  assign pulse_out = pulse_q;
  assign busy      = (state_q != StIdle);
  assign active_ch = active_q;
  assign pending   = pending_q;
  assign dropped   = dropped_q;

endmodule

// File: tb/tb_reset_req_sequencer.sv
// Bench for reset_req_sequencer: two instances (PREEMPT=0 and PREEMPT=1) on shared stimulus,
// each checked every cycle against a delay-line / countdown model plus literal expectations.
module tb_reset_req_sequencer;

  localparam int NCH  = 3;
  localparam int CW   = 8;
  localparam int GAPV = 4;
  localparam int SS   = 2;
  localparam logic [23:0] PLEN = {8'd31, 8'd2, 8'd6};

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [2:0] req_in = 3'b000;

  logic [2:0] pulse_out [2];
  logic       busy      [2];
  logic [1:0] active_ch [2];
  logic [2:0] pending   [2];
  logic       dropped   [2];

  reset_req_sequencer #(.PREEMPT(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .req_in(req_in), .pulse_out(pulse_out[0]), .busy(busy[0]),
    .active_ch(active_ch[0]), .pending(pending[0]), .dropped(dropped[0])
  );
  reset_req_sequencer #(.PREEMPT(1'b1)) dut1 (
    .clk(clk), .rst_n(rst_n), .req_in(req_in), .pulse_out(pulse_out[1]), .busy(busy[1]),
    .active_ch(active_ch[1]), .pending(pending[1]), .dropped(dropped[1])
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: smp[0] is the newest req_in sample; pl = pulse cycles left, gl = guard cycles left.
  typedef struct packed {
    logic [2:0]      pend;
    logic [2:0][2:0] smp;
    int              ch;
    int              pl;
    int              gl;
    logic            drop;
  } mst_t;

  localparam mst_t MRST = '{pend: 3'b000, smp: '1, ch: 0, pl: 0, gl: 0, drop: 1'b0};

  mst_t m [2];

  function automatic mst_t step(input mst_t s, input logic [2:0] rq, input bit pre);
    mst_t n;
    logic [2:0] e, cons;
    n      = s;
    e      = s.smp[SS-1] & ~s.smp[SS];
    cons   = 3'b000;
    n.drop = 1'b0;
    if (s.pl == 0 && s.gl == 0) begin
      if (s.pend != 0) begin
        for (int i = NCH - 1; i >= 0; i--) if (s.pend[i]) n.ch = i;
        cons = 3'b001 << n.ch;
        n.pl = (PLEN[n.ch*CW +: CW] == 0) ? 1 : int'(PLEN[n.ch*CW +: CW]);
      end
    end else if (s.pl > 0) begin
      if (pre && ((s.pend & ((3'b001 << s.ch) - 3'b001)) != 0)) begin
        n.pl   = 0;
        n.gl   = GAPV;
        n.drop = 1'b1;
      end else begin
        n.pl = s.pl - 1;
        if (n.pl == 0) n.gl = GAPV;
      end
    end else begin
      n.gl = s.gl - 1;
    end
    n.pend = (s.pend & ~cons) | e;
    if ((e & s.pend & ~cons) != 0) n.drop = 1'b1;
    n.smp = {s.smp[1:0], rq};
    return n;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m[0] <= MRST;
      m[1] <= MRST;
    end else begin
      m[0] <= step(m[0], req_in, 1'b0);
      m[1] <= step(m[1], req_in, 1'b1);
    end
  end

  // Per-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    if (rst_n) begin
      for (int p = 0; p < 2; p++) begin
        chk($sformatf("pulse_out[%0d]", p), 32'(pulse_out[p]),
            (m[p].pl > 0) ? 32'(3'b001 << m[p].ch) : 32'd0);
        chk($sformatf("busy[%0d]", p), 32'(busy[p]), 32'(m[p].pl > 0 || m[p].gl > 0));
        chk($sformatf("active_ch[%0d]", p), 32'(active_ch[p]),
            (m[p].pl > 0 || m[p].gl > 0) ? 32'(m[p].ch) : 32'd0);
        chk($sformatf("pending[%0d]", p), 32'(pending[p]), 32'(m[p].pend));
        chk($sformatf("dropped[%0d]", p), 32'(dropped[p]), 32'(m[p].drop));
        chk($sformatf("onehot[%0d]", p), 32'($countones(pulse_out[p]) <= 1), 32'd1);
      end
    end
  end

  // Pulse/drop statistics for the literal end-of-test expectations.
  int         rise_cnt [2][3] = '{default: 0};
  int         last_len [2][3] = '{default: 0};
  int         run      [2]    = '{default: 0};
  int         drop_cnt [2]    = '{default: 0};
  logic [2:0] prev     [2]    = '{default: 3'b000};
  int         order_q [$];

  always @(negedge clk) begin
    for (int p = 0; p < 2; p++) begin
      if (rst_n && dropped[p]) drop_cnt[p] <= drop_cnt[p] + 1;
      for (int c = 0; c < 3; c++) begin
        if (pulse_out[p][c] && !prev[p][c]) begin
          rise_cnt[p][c] <= rise_cnt[p][c] + 1;
          if (p == 0) order_q.push_back(c);
        end
        if (!pulse_out[p][c] && prev[p][c]) last_len[p][c] <= run[p];
      end
      run[p]  <= (pulse_out[p] == 3'b000) ? 0 : (pulse_out[p] == prev[p]) ? run[p] + 1 : 1;
      prev[p] <= pulse_out[p];
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic wait_quiet(input int budget);
    int n;
    n = 0;
    cyc(4);
    while ((busy[0] || busy[1] || pending[0] != 0 || pending[1] != 0) && n < budget) begin
      cyc(1);
      n++;
    end
    chk("quiet_timeout", 32'(n < budget), 32'd1);
  endtask

  task automatic wait_pulse(input int p, input logic [2:0] v, input int budget);
    int n;
    n = 0;
    while (pulse_out[p] !== v && n < budget) begin
      cyc(1);
      n++;
    end
    chk("wait_pulse", 32'(pulse_out[p]), 32'(v));
  endtask

  int r0 [2][3];
  int d0 [2];
  int q0;
  int lat;

  task automatic snap();
    for (int p = 0; p < 2; p++) begin
      d0[p] = drop_cnt[p];
      for (int c = 0; c < 3; c++) r0[p][c] = rise_cnt[p][c];
    end
    q0 = order_q.size();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    #1 rst_n = 1'b0;
    cyc(3);
    chk("rst_pulse_out", 32'(pulse_out[0]), 32'd0);
    chk("rst_busy", 32'(busy[0]), 32'd0);
    chk("rst_pending", 32'(pending[0]), 32'd0);
    chk("rst_active_ch", 32'(active_ch[0]), 32'd0);
    chk("rst_dropped", 32'(dropped[0]), 32'd0);
    rst_n = 1'b1;
    cyc(2);

    // Single request on ch0: latency counted in edges including the sampling edge.
    snap();
    req_in = 3'b001;
    lat = 0;
    while (!pulse_out[0][0] && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk("latency_ch0", 32'(lat), 32'd4);
    wait_quiet(100);
    chk("single_len_ch0", 32'(last_len[0][0]), 32'd6);
    chk("single_rises_ch0", 32'(rise_cnt[0][0] - r0[0][0]), 32'd1);

    // Simultaneous requests: served ch0, ch1, ch2 with no drops.
    req_in = 3'b000;
    cyc(6);
    snap();
    req_in = 3'b111;
    wait_quiet(200);
    chk("simul_count", 32'(order_q.size() - q0), 32'd3);
    if (order_q.size() >= q0 + 3) begin
      chk("simul_first", 32'(order_q[q0]), 32'd0);
      chk("simul_second", 32'(order_q[q0+1]), 32'd1);
      chk("simul_third", 32'(order_q[q0+2]), 32'd2);
    end
    chk("simul_len_ch0", 32'(last_len[0][0]), 32'd6);
    chk("simul_len_ch1", 32'(last_len[0][1]), 32'd2);
    chk("simul_len_ch2", 32'(last_len[0][2]), 32'd31);
    chk("simul_drops", 32'(drop_cnt[0] - d0[0]), 32'd0);

    // Overflow: three ch2 edges 4 cycles apart while ch0 is being served.
    req_in = 3'b000;
    cyc(6);
    snap();
    req_in = 3'b001; cyc(1);
    req_in = 3'b101; cyc(2);
    req_in = 3'b001; cyc(2);
    req_in = 3'b101; cyc(2);
    req_in = 3'b001; cyc(2);
    req_in = 3'b101;
    wait_quiet(200);
    chk("ovf_drops", 32'(drop_cnt[0] - d0[0]), 32'd2);
    chk("ovf_rises_ch2", 32'(rise_cnt[0][2] - r0[0][2]), 32'd1);
    chk("ovf_len_ch2", 32'(last_len[0][2]), 32'd31);
    chk("ovf_rises_ch0", 32'(rise_cnt[0][0] - r0[0][0]), 32'd1);

    // Pre-emption: ch0 request arrives 10 cycles into a ch2 pulse.
    req_in = 3'b000;
    cyc(6);
    snap();
    req_in = 3'b100;
    wait_pulse(1, 3'b100, 20);
    cyc(10);
    req_in = 3'b101;
    wait_quiet(200);
    chk("pre_truncated_ch2", 32'(last_len[1][2] < 31), 32'd1);
    chk("pre_drops", 32'(drop_cnt[1] - d0[1]), 32'd1);
    chk("pre_len_ch0", 32'(last_len[1][0]), 32'd6);
    chk("pre_rises_ch0", 32'(rise_cnt[1][0] - r0[1][0]), 32'd1);
    chk("nopre_len_ch2", 32'(last_len[0][2]), 32'd31);
    chk("nopre_len_ch0", 32'(last_len[0][0]), 32'd6);
    chk("nopre_drops", 32'(drop_cnt[0] - d0[0]), 32'd0);
    chk("nopre_order", 32'(order_q.size() == q0 + 2 && order_q[q0] == 2 && order_q[q0+1] == 0),
        32'd1);

    // Reset-safety: lines already high at release produce nothing.
    rst_n  = 1'b0;
    req_in = 3'b111;
    cyc(2);
    rst_n = 1'b1;
    snap();
    cyc(10);
    chk("rsafe_pending", 32'(pending[0]), 32'd0);
    chk("rsafe_no_pulse", 32'(rise_cnt[0][0] + rise_cnt[0][1] + rise_cnt[0][2]
                              - r0[0][0] - r0[0][1] - r0[0][2]), 32'd0);
    req_in = 3'b101;
    cyc(4);
    req_in = 3'b111;
    wait_quiet(100);
    chk("rsafe_rises_ch1", 32'(rise_cnt[0][1] - r0[0][1]), 32'd1);
    chk("rsafe_len_ch1", 32'(last_len[0][1]), 32'd2);
    chk("rsafe_rises_ch02", 32'(rise_cnt[0][0] + rise_cnt[0][2] - r0[0][0] - r0[0][2]), 32'd0);

    // Reset mid-pulse with ch0/ch1 queued behind ch2.
    req_in = 3'b000;
    cyc(6);
    req_in = 3'b100; cyc(1);
    req_in = 3'b111;
    wait_pulse(0, 3'b100, 20);
    cyc(2);
    chk("mid_pending_before", 32'(pending[0]), 32'd3);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_pulse_cleared", 32'(pulse_out[0]), 32'd0);
    chk("mid_pending_cleared", 32'(pending[0]), 32'd0);
    chk("mid_busy_cleared", 32'(busy[0]), 32'd0);
    chk("mid_pulse1_cleared", 32'(pulse_out[1]), 32'd0);
    cyc(2);
    rst_n = 1'b1;
    snap();
    cyc(40);
    chk("mid_no_pulse", 32'(rise_cnt[0][0] + rise_cnt[0][1] + rise_cnt[0][2]
                            - r0[0][0] - r0[0][1] - r0[0][2]), 32'd0);
    chk("mid_pending_after", 32'(pending[0]), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
